l2_cache_update_queue: RTL

- Parameterised next-generation L2 update stage. Sits after l2_cache_read_stage and drives the cache write port.
- Merges store data into the line using the byte mask, the same as the current update stage.
- New: responses are queued in a DEPTH-entry FIFO with a valid/ready handshake toward the cores.
- New: the cache line is serialised over a narrower response bus in RSP_BEATS beats.
- New: upstream is throttled through a stall output.

---
 rtl/l2_cache_update_queue_pkg.sv | 46 ++++
 rtl/l2_cache_update_queue_if.sv | 36 +++
 rtl/l2_response_fifo.sv | 44 ++++
 rtl/l2_cache_update_queue.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/l2_cache_update_queue_pkg.sv
// Shared request/response encodings and the queued response header for the
// L2 update stage.
package l2_cache_update_queue_pkg;

  localparam int unsigned L2U_CORE_ID_W = 2;
  localparam int unsigned L2U_REQ_ID_W  = 2;
  localparam int unsigned L2U_ADDR_W    = 26;

  typedef enum logic [2:0] {
    L2REQ_LOAD        = 3'd0,
    L2REQ_STORE       = 3'd1,
    L2REQ_FLUSH       = 3'd2,
    L2REQ_IINVALIDATE = 3'd3,
    L2REQ_DINVALIDATE = 3'd4,
    L2REQ_LOAD_SYNC   = 3'd5,
    L2REQ_STORE_SYNC  = 3'd6
  } l2req_type_t;

  typedef enum logic [2:0] {
    L2RSP_LOAD_ACK        = 3'd0,
    L2RSP_STORE_ACK       = 3'd1,
    L2RSP_FLUSH_ACK       = 3'd2,
    L2RSP_IINVALIDATE_ACK = 3'd3,
    L2RSP_DINVALIDATE_ACK = 3'd4
  } l2rsp_type_t;

  typedef struct packed {
    logic [L2U_CORE_ID_W-1:0] core;
    logic [L2U_REQ_ID_W-1:0]  id;
    l2rsp_type_t              packet_type;
    logic                     cache_type;
    logic [L2U_ADDR_W-1:0]    address;
    logic                     status;
  } l2u_rsp_header_t;

  function automatic l2rsp_type_t rsp_type_of(l2req_type_t req);
    case (req)
      L2REQ_STORE, L2REQ_STORE_SYNC: return L2RSP_STORE_ACK;
      L2REQ_FLUSH:                   return L2RSP_FLUSH_ACK;
      L2REQ_IINVALIDATE:             return L2RSP_IINVALIDATE_ACK;
      L2REQ_DINVALIDATE:             return L2RSP_DINVALIDATE_ACK;
      default:                       return L2RSP_LOAD_ACK;
    endcase
  endfunction

endpackage

// File: rtl/l2_cache_update_queue_if.sv
// Beat-serialised response channel from the L2 update stage to the cores.
interface l2_cache_update_queue_if
  import l2_cache_update_queue_pkg::*;
#(
  parameter int unsigned CORE_ID_W = 2,
  parameter int unsigned REQ_ID_W  = 2,
  parameter int unsigned ADDR_W    = 26,
  parameter int unsigned BEAT_W    = 1,
  parameter int unsigned BEAT_DW   = 256
) ();
  logic                 l2_response_valid;
  logic                 l2_response_ready;
  logic [CORE_ID_W-1:0] l2_response_core;
  logic [REQ_ID_W-1:0]  l2_response_id;
  l2rsp_type_t          l2_response_type;
  logic                 l2_response_cache_type;
  logic [ADDR_W-1:0]    l2_response_address;
  logic                 l2_response_status;
  logic [BEAT_W-1:0]    l2_response_beat;
  logic                 l2_response_last;
  logic [BEAT_DW-1:0]   l2_response_data;

  modport master (
    output l2_response_valid, l2_response_core, l2_response_id, l2_response_type,
           l2_response_cache_type, l2_response_address, l2_response_status,
           l2_response_beat, l2_response_last, l2_response_data,
    input  l2_response_ready
  );

  modport slave (
    input  l2_response_valid, l2_response_core, l2_response_id, l2_response_type,
           l2_response_cache_type, l2_response_address, l2_response_status,
           l2_response_beat, l2_response_last, l2_response_data,
    output l2_response_ready
  );
endinterface

// File: rtl/l2_response_fifo.sv
// Power-of-two FIFO with occupancy count; storage itself is not reset.
module l2_response_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok && !pop_ok)      count <= count + CNT_W'(1);
      else if (pop_ok && !push_ok) count <= count - CNT_W'(1);
    end
  end
endmodule

// File: rtl/l2_cache_update_queue.sv
// L2 update stage: merges store data into the line for the cache write port and
// queues responses that are serialised to the cores in RSP_BEATS beats.
module l2_cache_update_queue
  import l2_cache_update_queue_pkg::*;
#(
  parameter int unsigned LINE_BYTES   = 64,
  parameter int unsigned CACHE_IDX_W  = 10,
  parameter int unsigned ADDR_W       = L2U_ADDR_W,
  parameter int unsigned CORE_ID_W    = L2U_CORE_ID_W,
  parameter int unsigned REQ_ID_W     = L2U_REQ_ID_W,
  parameter int unsigned RSP_DEPTH    = 4,
  parameter int unsigned RSP_BEATS    = 2,
  parameter int unsigned STALL_MARGIN = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      l2r_request_valid,
  input  l2req_type_t               l2r_packet_type,
  input  logic [CORE_ID_W-1:0]      l2r_core,
  input  logic [REQ_ID_W-1:0]       l2r_id,
  input  logic                      l2r_cache_type,
  input  logic [ADDR_W-1:0]         l2r_address,
  input  logic [LINE_BYTES-1:0]     l2r_store_mask,
  input  logic [LINE_BYTES*8-1:0]   l2r_store_data,
  input  logic [LINE_BYTES*8-1:0]   l2r_data,
  input  logic [LINE_BYTES*8-1:0]   l2r_data_from_memory,
  input  logic                      l2r_cache_hit,
  input  logic [CACHE_IDX_W-1:0]    l2r_hit_cache_idx,
  input  logic                      l2r_l2_fill,
  input  logic                      l2r_restarted_flush,
  input  logic                      l2r_store_sync_success,
  input  logic                      l2r_needs_writeback,
  output logic                      l2u_write_en,
  output logic [CACHE_IDX_W-1:0]    l2u_write_addr,
  output logic [LINE_BYTES*8-1:0]   l2u_write_data,
  output logic                      l2u_stall,
  output logic                      l2u_overflow,
  l2_cache_update_queue_if.master   rsp
);
  localparam int unsigned DATA_W  = LINE_BYTES * 8;
  localparam int unsigned BEAT_DW = DATA_W / RSP_BEATS;
  localparam int unsigned BEAT_W  = (RSP_BEATS > 1) ? $clog2(RSP_BEATS) : 1;
  localparam int unsigned BCNT_W  = $clog2(RSP_BEATS) + 1;
  localparam int unsigned CNT_W   = $clog2(RSP_DEPTH) + 1;

  typedef struct packed {
    l2u_rsp_header_t   hdr;
    logic [DATA_W-1:0] data;
    logic [BCNT_W-1:0] beats;
  } entry_t;

  logic              is_store, do_merge, completed_flush, enq, pop, full, empty, last_beat;
  logic              ovf_evt, single_beat;
  logic [DATA_W-1:0] orig_line, merged_line;
  logic [CNT_W-1:0]  count;
  logic [BEAT_W-1:0] beat_cnt;
  l2rsp_type_t       rsp_type;
  entry_t            enq_entry, head;

  assign is_store = (l2r_packet_type == L2REQ_STORE) | (l2r_packet_type == L2REQ_STORE_SYNC);
  assign do_merge = (l2r_packet_type == L2REQ_STORE)
                  | ((l2r_packet_type == L2REQ_STORE_SYNC) & l2r_store_sync_success);

  always_comb begin
    orig_line   = l2r_l2_fill ? l2r_data_from_memory : l2r_data;
    merged_line = orig_line;
    for (int unsigned i = 0; i < LINE_BYTES; i++) begin
      if (do_merge && l2r_store_mask[i]) merged_line[i*8 +: 8] = l2r_store_data[i*8 +: 8];
    end
  end

  assign l2u_write_en   = l2r_request_valid & (l2r_l2_fill | (l2r_cache_hit & is_store));
  assign l2u_write_addr = l2r_hit_cache_idx;
  assign l2u_write_data = merged_line;

  // A dirty hit flush is answered only on its restarted pass, after writeback.
  assign completed_flush = (l2r_packet_type == L2REQ_FLUSH)
                         & (l2r_restarted_flush | ~l2r_cache_hit | ~l2r_needs_writeback);
  assign enq = l2r_request_valid
             & ((l2r_cache_hit & (l2r_packet_type != L2REQ_FLUSH)) | l2r_l2_fill | completed_flush
                | (l2r_packet_type == L2REQ_DINVALIDATE) | (l2r_packet_type == L2REQ_IINVALIDATE));

  always_comb begin
    rsp_type    = rsp_type_of(l2r_packet_type);
    single_beat = (rsp_type == L2RSP_FLUSH_ACK) | (rsp_type == L2RSP_IINVALIDATE_ACK)
                | (rsp_type == L2RSP_DINVALIDATE_ACK);
    enq_entry.hdr.core        = l2r_core;
    enq_entry.hdr.id          = l2r_id;
    enq_entry.hdr.packet_type = rsp_type;
    enq_entry.hdr.cache_type  = l2r_cache_type;
    enq_entry.hdr.address     = l2r_address;
    enq_entry.hdr.status      = (l2r_packet_type == L2REQ_STORE_SYNC) ? l2r_store_sync_success : 1'b1;
    enq_entry.data            = single_beat ? '0 : merged_line;
    enq_entry.beats           = single_beat ? BCNT_W'(1) : BCNT_W'(RSP_BEATS);
  end

  l2_response_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (RSP_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (enq),
    .pop     (pop),
    .wdata   (enq_entry),
    .rdata   (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  assign last_beat = ((BCNT_W'(beat_cnt) + BCNT_W'(1)) == head.beats);
  assign pop       = rsp.l2_response_valid & rsp.l2_response_ready & last_beat;
  assign ovf_evt   = enq & full & ~pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_cnt     <= '0;
      l2u_overflow <= 1'b0;
    end else begin
      if (rsp.l2_response_valid && rsp.l2_response_ready)
        beat_cnt <= last_beat ? '0 : beat_cnt + BEAT_W'(1);
      if (ovf_evt) l2u_overflow <= 1'b1;
    end
  end

  assign l2u_stall = (CNT_W'(RSP_DEPTH) - count) <= CNT_W'(STALL_MARGIN);

  assign rsp.l2_response_valid      = ~empty;
  assign rsp.l2_response_core       = head.hdr.core;
  assign rsp.l2_response_id         = head.hdr.id;
  assign rsp.l2_response_type       = head.hdr.packet_type;
  assign rsp.l2_response_cache_type = head.hdr.cache_type;
  assign rsp.l2_response_address    = head.hdr.address;
  assign rsp.l2_response_status     = head.hdr.status;
  assign rsp.l2_response_beat       = beat_cnt;
  assign rsp.l2_response_last       = last_beat;
  assign rsp.l2_response_data       = head.data[int'(beat_cnt) * BEAT_DW +: BEAT_DW];

  a_restart_is_flush: assert property (@(posedge clk) disable iff (!reset_n)
    l2r_restarted_flush |-> (l2r_packet_type == L2REQ_FLUSH));
  a_restart_not_fill: assert property (@(posedge clk) disable iff (!reset_n)
    !(l2r_restarted_flush && l2r_l2_fill));
  a_overflow_flagged: assert property (@(posedge clk) disable iff (!reset_n)
    ovf_evt |=> l2u_overflow);
  c_overflow: cover property (@(posedge clk) disable iff (!reset_n) ovf_evt);
endmodule
